saxi_write_broadcastor_nway: RTL and testbench

- Parametrised N-way broadcaster for the AXI-Lite control slave write path (AW, W, B) of a multi-SLR kernel.
- Sits between the host-facing `s_axi_control` write port and NUM_BRANCH per-SLR control-register copies.
- Guarantees every branch receives exactly one copy of each AW beat and each W beat, even when branch readies differ.
- Merges the NUM_BRANCH write responses into one B beat carrying the worst response.

---
 rtl/saxi_write_broadcastor_nway_if.sv | 66 ++++++
 rtl/saxi_write_broadcastor_nway.sv | 203 ++++++++++++++++++++
 tb/tb_saxi_write_broadcastor_nway.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/saxi_write_broadcastor_nway_if.sv
// AXI-Lite control write-path bundle for the N-way broadcaster: one upstream
// write port (AW/W/B) and NUM_BRANCH flattened downstream write ports.
// Branch i occupies bits [i*W +: W] of every per-branch vector.
interface saxi_write_broadcastor_nway_if #(
  parameter int NUM_BRANCH = 3,
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 32
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  // Upstream (host-facing) write port
  logic                             s_axi_control_AWVALID;
  logic                             s_axi_control_AWREADY;
  logic [ADDR_WIDTH-1:0]            s_axi_control_AWADDR;
  logic                             s_axi_control_WVALID;
  logic                             s_axi_control_WREADY;
  logic [DATA_WIDTH-1:0]            s_axi_control_WDATA;
  logic [STRB_WIDTH-1:0]            s_axi_control_WSTRB;
  logic                             s_axi_control_BVALID;
  logic                             s_axi_control_BREADY;
  logic [1:0]                       s_axi_control_BRESP;

  // Downstream per-branch write ports
  logic [NUM_BRANCH-1:0]            m_axi_AWVALID;
  logic [NUM_BRANCH-1:0]            m_axi_AWREADY;
  logic [NUM_BRANCH*ADDR_WIDTH-1:0] m_axi_AWADDR;
  logic [NUM_BRANCH-1:0]            m_axi_WVALID;
  logic [NUM_BRANCH-1:0]            m_axi_WREADY;
  logic [NUM_BRANCH*DATA_WIDTH-1:0] m_axi_WDATA;
  logic [NUM_BRANCH*STRB_WIDTH-1:0] m_axi_WSTRB;
  logic [NUM_BRANCH-1:0]            m_axi_BVALID;
  logic [NUM_BRANCH-1:0]            m_axi_BREADY;
  logic [NUM_BRANCH*2-1:0]          m_axi_BRESP;

  // Broadcaster side: slave towards the host, master towards the branches
  modport slave (
    input  s_axi_control_AWVALID, s_axi_control_AWADDR,
    output s_axi_control_AWREADY,
    input  s_axi_control_WVALID, s_axi_control_WDATA, s_axi_control_WSTRB,
    output s_axi_control_WREADY,
    output s_axi_control_BVALID, s_axi_control_BRESP,
    input  s_axi_control_BREADY,
    output m_axi_AWVALID, m_axi_AWADDR,
    input  m_axi_AWREADY,
    output m_axi_WVALID, m_axi_WDATA, m_axi_WSTRB,
    input  m_axi_WREADY,
    input  m_axi_BVALID, m_axi_BRESP,
    output m_axi_BREADY
  );

  // Environment side: drives the host port and emulates the branches
  modport master (
    output s_axi_control_AWVALID, s_axi_control_AWADDR,
    input  s_axi_control_AWREADY,
    output s_axi_control_WVALID, s_axi_control_WDATA, s_axi_control_WSTRB,
    input  s_axi_control_WREADY,
    input  s_axi_control_BVALID, s_axi_control_BRESP,
    output s_axi_control_BREADY,
    input  m_axi_AWVALID, m_axi_AWADDR,
    output m_axi_AWREADY,
    input  m_axi_WVALID, m_axi_WDATA, m_axi_WSTRB,
    output m_axi_WREADY,
    output m_axi_BVALID, m_axi_BRESP,
    input  m_axi_BREADY
  );
endinterface

// File: rtl/saxi_write_broadcastor_nway.sv
// N-way AXI-Lite write broadcaster. AW and W each pass through an independent
// one-entry hold engine that fans a beat out to every branch exactly once;
// the branch B responses are merged into one upstream B carrying the worst code.

// One-entry broadcast buffer: EMPTY accepts a beat, HOLD offers it to every
// branch until each branch has taken exactly one copy.
module saxi_write_broadcastor_nway_engine #(
  parameter int NUM_BRANCH    = 3,
  parameter int PAYLOAD_WIDTH = 9
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [PAYLOAD_WIDTH-1:0] in_payload,
  output logic [NUM_BRANCH-1:0]    out_valid,
  input  logic [NUM_BRANCH-1:0]    out_ready,
  output logic [PAYLOAD_WIDTH-1:0] out_payload
);
  typedef enum logic {
    EMPTY = 1'b0,
    HOLD  = 1'b1
  } state_t;

  state_t                  state_q, state_d;
  logic                    ready_q, ready_d;
  logic [NUM_BRANCH-1:0]   sent_q, sent_d;
  logic [NUM_BRANCH-1:0]   handshake;
  logic [PAYLOAD_WIDTH-1:0] hold_q;
  logic                    accept;

  // Ready is a register so it stays low through reset and rises one cycle
  // after release, independent of the state encoding.
  assign in_ready    = ready_q;
  assign accept      = in_valid & ready_q;
  assign out_valid   = (state_q == HOLD) ? ~sent_q : '0;
  assign out_payload = hold_q;
  assign handshake   = out_valid & out_ready;

  // Next-state, sent mask and upstream ready for the following cycle
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
    state_d = state_q;
    sent_d  = sent_q;
    case (state_q)
      EMPTY: begin
        if (accept) begin
          state_d = HOLD;
          sent_d  = '0;
        end
      end
      HOLD: begin
        sent_d = sent_q | handshake;
        if (&sent_d) begin
          state_d = EMPTY;
        end
      end
    endcase
    ready_d = (state_d == EMPTY);
  end

  // State, sent mask and ready registers
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    if (rst) begin
      state_q <= EMPTY;
      sent_q  <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sent_q  <= sent_d;
      ready_q <= ready_d;
    end
  end

  // Payload capture on upstream acceptance
  always_ff @(posedge clk) begin
    // NOTE: the payload needs no reset; it is never observed while the engine is EMPTY.
    if (accept) begin
      hold_q <= in_payload;
    end
  end
endmodule

module saxi_write_broadcastor_nway #(
  parameter int NUM_BRANCH = 3,
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 32
) (
  input logic                          ap_clk,
  input logic                          ap_rst,
  saxi_write_broadcastor_nway_if.slave bus
);
  localparam int STRB_WIDTH      = DATA_WIDTH / 8;
  localparam int W_PAYLOAD_WIDTH = STRB_WIDTH + DATA_WIDTH;

  typedef enum logic {
    B_WAIT = 1'b0,
    B_RESP = 1'b1
  } b_state_t;

  logic [ADDR_WIDTH-1:0]      aw_payload;
  logic [W_PAYLOAD_WIDTH-1:0] w_payload;

  b_state_t              b_state_q, b_state_d;
  logic [NUM_BRANCH-1:0] got_q, got_d;
  logic [NUM_BRANCH-1:0] bready_q, bready_d;
  logic [NUM_BRANCH-1:0] b_handshake;
  logic [1:0]            worst_q, worst_d;
  logic                  bvalid_q, bvalid_d;
  logic                  b_done;

  // ---------------- AW channel ----------------
  saxi_write_broadcastor_nway_engine #(
    .NUM_BRANCH    (NUM_BRANCH),
    .PAYLOAD_WIDTH (ADDR_WIDTH)
  ) u_aw_engine (
    .clk         (ap_clk),
    .rst         (ap_rst),
    .in_valid    (bus.s_axi_control_AWVALID),
    .in_ready    (bus.s_axi_control_AWREADY),
    .in_payload  (bus.s_axi_control_AWADDR),
    .out_valid   (bus.m_axi_AWVALID),
    .out_ready   (bus.m_axi_AWREADY),
    .out_payload (aw_payload)
  );

  assign bus.m_axi_AWADDR = {NUM_BRANCH{aw_payload}};

  // ---------------- W channel ----------------
  saxi_write_broadcastor_nway_engine #(
    .NUM_BRANCH    (NUM_BRANCH),
    .PAYLOAD_WIDTH (W_PAYLOAD_WIDTH)
  ) u_w_engine (
    .clk         (ap_clk),
    .rst         (ap_rst),
    .in_valid    (bus.s_axi_control_WVALID),
    .in_ready    (bus.s_axi_control_WREADY),
    .in_payload  ({bus.s_axi_control_WSTRB, bus.s_axi_control_WDATA}),
    .out_valid   (bus.m_axi_WVALID),
    .out_ready   (bus.m_axi_WREADY),
    .out_payload (w_payload)
  );

  assign bus.m_axi_WDATA = {NUM_BRANCH{w_payload[DATA_WIDTH-1:0]}};
  assign bus.m_axi_WSTRB = {NUM_BRANCH{w_payload[W_PAYLOAD_WIDTH-1:DATA_WIDTH]}};

  // ---------------- B merge ----------------
  // Branch BREADY is registered, so a branch is accepted only when its got
  // bit was clear at the start of the cycle and the merge is collecting.
  assign b_handshake              = bus.m_axi_BVALID & bready_q;
  assign b_done                   = bvalid_q & bus.s_axi_control_BREADY;
  assign bus.m_axi_BREADY         = bready_q;
  assign bus.s_axi_control_BVALID = bvalid_q;
  assign bus.s_axi_control_BRESP  = worst_q;

  // Collect one response per branch keeping the numerically largest code,
  // then present it upstream until it is taken.
  always_comb begin
    b_state_d = b_state_q;
    got_d     = got_q;
    worst_d   = worst_q;
    case (b_state_q)
      B_WAIT: begin
        got_d = got_q | b_handshake;
        for (int i = 0; i < NUM_BRANCH; i++) begin
          if (b_handshake[i] && (bus.m_axi_BRESP[2*i +: 2] > worst_d)) begin
            worst_d = bus.m_axi_BRESP[2*i +: 2];
          end
        end
        if (&got_d) begin
          b_state_d = B_RESP;
        end
      end
      B_RESP: begin
        if (b_done) begin
          b_state_d = B_WAIT;
          got_d     = '0;
          worst_d   = 2'b00;
        end
      end
    endcase
    bvalid_d = (b_state_d == B_RESP);
    bready_d = (b_state_d == B_WAIT) ? ~got_d : '0;
  end

  // B merge state, masks and registered handshake outputs
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      b_state_q <= B_WAIT;
      got_q     <= '0;
      worst_q   <= 2'b00;
      bvalid_q  <= 1'b0;
      bready_q  <= '0;
    end else begin
      b_state_q <= b_state_d;
      got_q     <= got_d;
      worst_q   <= worst_d;
      bvalid_q  <= bvalid_d;
      bready_q  <= bready_d;
    end
  end
endmodule

// File: tb/tb_saxi_write_broadcastor_nway.sv
// Bench for the N-way write broadcaster: directed timing steps followed by a
// randomized phase, all cross-checked by a queue-based delivery/merge model.
module tb_saxi_write_broadcastor_nway;
  localparam int NB = 3;
  localparam int AW = 9;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int WP = SW + DW;

  logic ap_clk = 1'b0;
  logic ap_rst = 1'b1;
  int   total  = 0;
  int   bad    = 0;

  saxi_write_broadcastor_nway_if #(.NUM_BRANCH(NB), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  saxi_write_broadcastor_nway #(.NUM_BRANCH(NB), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .ap_clk (ap_clk),
    .ap_rst (ap_rst),
    .bus    (bus)
  );

  always #5 ap_clk = ~ap_clk;

  // Model: every accepted upstream beat must reach each branch exactly once,
  // in order; the k-th upstream B is the max of each branch's k-th response.
  logic [AW-1:0] aw_q [NB][$];
  logic [WP-1:0] w_q  [NB][$];
  logic [1:0]    b_q  [NB][$];

  logic [NB-1:0]    prev_awv, prev_awhs, prev_wv, prev_whs;
  logic [NB*AW-1:0] prev_awaddr;
  logic [NB*DW-1:0] prev_wdata;
  logic [NB*SW-1:0] prev_wstrb;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Evaluate the handshakes that the coming rising edge will complete.
  task automatic tick();
    logic [NB-1:0] awhs, whs, bhs;
    logic [1:0]    want;
    logic          all_in;
    if (ap_rst) begin
      for (int i = 0; i < NB; i++) begin
        aw_q[i].delete();
        w_q[i].delete();
        b_q[i].delete();
      end
      prev_awv = '0; prev_awhs = '0; prev_wv = '0; prev_whs = '0;
      return;
    end
    awhs = bus.m_axi_AWVALID & bus.m_axi_AWREADY;
    whs  = bus.m_axi_WVALID & bus.m_axi_WREADY;
    bhs  = bus.m_axi_BVALID & bus.m_axi_BREADY;
    for (int i = 0; i < NB; i++) begin
      if (prev_awv[i] && !prev_awhs[i]) begin
        check("aw_valid_held", bus.m_axi_AWVALID[i], 1'b1);
        check("aw_addr_stable", bus.m_axi_AWADDR[i*AW +: AW], prev_awaddr[i*AW +: AW]);
      end
      if (prev_wv[i] && !prev_whs[i]) begin
        check("w_valid_held", bus.m_axi_WVALID[i], 1'b1);
        check("w_data_stable", {bus.m_axi_WSTRB[i*SW +: SW], bus.m_axi_WDATA[i*DW +: DW]},
              {prev_wstrb[i*SW +: SW], prev_wdata[i*DW +: DW]});
      end
      if (awhs[i]) begin
        check("aw_beat_expected", aw_q[i].size() != 0, 1'b1);
        if (aw_q[i].size() != 0) check("aw_addr", bus.m_axi_AWADDR[i*AW +: AW], aw_q[i].pop_front());
      end
      if (whs[i]) begin
        check("w_beat_expected", w_q[i].size() != 0, 1'b1);
        if (w_q[i].size() != 0)
          check("w_payload", {bus.m_axi_WSTRB[i*SW +: SW], bus.m_axi_WDATA[i*DW +: DW]}, w_q[i].pop_front());
      end
    end
    if (bus.s_axi_control_BVALID && bus.s_axi_control_BREADY) begin
      all_in = 1'b1;
      want   = 2'd0;
      for (int i = 0; i < NB; i++) begin
        if (b_q[i].size() == 0) all_in = 1'b0;
        else if (b_q[i][0] > want) want = b_q[i][0];
      end
      check("b_all_branches_in", all_in, 1'b1);
      if (all_in) begin
        check("b_merged_resp", bus.s_axi_control_BRESP, want);
        for (int i = 0; i < NB; i++) void'(b_q[i].pop_front());
      end
    end
    for (int i = 0; i < NB; i++) begin
      if (bhs[i]) b_q[i].push_back(bus.m_axi_BRESP[i*2 +: 2]);
      if (bus.s_axi_control_AWVALID && bus.s_axi_control_AWREADY) aw_q[i].push_back(bus.s_axi_control_AWADDR);
      if (bus.s_axi_control_WVALID && bus.s_axi_control_WREADY)
        w_q[i].push_back({bus.s_axi_control_WSTRB, bus.s_axi_control_WDATA});
    end
    prev_awv = bus.m_axi_AWVALID; prev_awhs = awhs; prev_awaddr = bus.m_axi_AWADDR;
    prev_wv  = bus.m_axi_WVALID;  prev_whs  = whs;
    prev_wdata = bus.m_axi_WDATA; prev_wstrb = bus.m_axi_WSTRB;
  endtask

  // One clock: model update, edge, then retire valids that were accepted.
  task automatic step();
    logic          aw_acc, w_acc;
    logic [NB-1:0] bhs;
    tick();
    aw_acc = !ap_rst && bus.s_axi_control_AWVALID && bus.s_axi_control_AWREADY;
    w_acc  = !ap_rst && bus.s_axi_control_WVALID && bus.s_axi_control_WREADY;
    bhs    = ap_rst ? '0 : (bus.m_axi_BVALID & bus.m_axi_BREADY);
    @(posedge ap_clk);
    @(negedge ap_clk);
    if (aw_acc) bus.s_axi_control_AWVALID = 1'b0;
    if (w_acc)  bus.s_axi_control_WVALID  = 1'b0;
    bus.m_axi_BVALID = bus.m_axi_BVALID & ~bhs;
  endtask

  initial begin
    prev_awv = '0; prev_awhs = '0; prev_wv = '0; prev_whs = '0;
    prev_awaddr = '0; prev_wdata = '0; prev_wstrb = '0;
    bus.s_axi_control_AWVALID = 1'b1;
    bus.s_axi_control_AWADDR  = 9'h055;
    bus.s_axi_control_WVALID  = 1'b0;
    bus.s_axi_control_WDATA   = '0;
    bus.s_axi_control_WSTRB   = '0;
    bus.s_axi_control_BREADY  = 1'b0;
    bus.m_axi_AWREADY = '1;
    bus.m_axi_WREADY  = '1;
    bus.m_axi_BVALID  = '0;
    bus.m_axi_BRESP   = '0;
    @(negedge ap_clk);

    // Reset with a pending upstream AW: everything stays low
    repeat (3) begin
      check("rst_awready", bus.s_axi_control_AWREADY, 1'b0);
      check("rst_wready", bus.s_axi_control_WREADY, 1'b0);
      check("rst_bvalid", bus.s_axi_control_BVALID, 1'b0);
      check("rst_bresp", bus.s_axi_control_BRESP, 2'd0);
      check("rst_m_awvalid", bus.m_axi_AWVALID, 3'b000);
      check("rst_m_wvalid", bus.m_axi_WVALID, 3'b000);
      check("rst_m_bready", bus.m_axi_BREADY, 3'b000);
      step();
    end
    ap_rst = 1'b0;
    step();
    check("rel_awready", bus.s_axi_control_AWREADY, 1'b1);
    check("rel_wready", bus.s_axi_control_WREADY, 1'b1);
    check("rel_m_bready", bus.m_axi_BREADY, 3'b111);
    step();
    check("rel_aw_accepted", bus.s_axi_control_AWVALID, 1'b0);
    check("rel_m_awvalid", bus.m_axi_AWVALID, 3'b111);
    step();
    check("rel_awready_back", bus.s_axi_control_AWREADY, 1'b1);

    // Lockstep AW + W, all branches ready
    bus.s_axi_control_AWVALID = 1'b1; bus.s_axi_control_AWADDR = 9'h010;
    bus.s_axi_control_WVALID  = 1'b1; bus.s_axi_control_WDATA  = 32'hDEADBEEF;
    bus.s_axi_control_WSTRB   = 4'hF;
    step();
    check("lock_m_awvalid", bus.m_axi_AWVALID, 3'b111);
    check("lock_m_wvalid", bus.m_axi_WVALID, 3'b111);
    check("lock_awaddr_rep", bus.m_axi_AWADDR, {NB{9'h010}});
    check("lock_wdata_rep", bus.m_axi_WDATA, {NB{32'hDEADBEEF}});
    check("lock_awready_busy", bus.s_axi_control_AWREADY, 1'b0);
    step();
    check("lock_awready_t2", bus.s_axi_control_AWREADY, 1'b1);
    check("lock_wready_t2", bus.s_axi_control_WREADY, 1'b1);
    check("lock_m_valid_done", {bus.m_axi_AWVALID, bus.m_axi_WVALID}, 6'b0);

    // Branch 1 AWREADY low for five cycles
    bus.m_axi_AWREADY = 3'b101;
    bus.s_axi_control_AWVALID = 1'b1; bus.s_axi_control_AWADDR = 9'h010;
    step();
    check("skew_m_awvalid_t1", bus.m_axi_AWVALID, 3'b111);
    step();
    repeat (4) begin
      check("skew_m_awvalid", bus.m_axi_AWVALID, 3'b010);
      check("skew_addr_b1", bus.m_axi_AWADDR[AW +: AW], 9'h010);
      check("skew_awready", bus.s_axi_control_AWREADY, 1'b0);
      step();
    end
    bus.m_axi_AWREADY = 3'b111;
    check("skew_m_awvalid_last", bus.m_axi_AWVALID, 3'b010);
    step();
    check("skew_awready_back", bus.s_axi_control_AWREADY, 1'b1);
    check("skew_m_awvalid_done", bus.m_axi_AWVALID, 3'b000);

    // Response merge: OKAY, SLVERR, OKAY at t, t+2, t+4
    check("merge_bready_t", bus.m_axi_BREADY, 3'b111);
    bus.m_axi_BVALID[0] = 1'b1; bus.m_axi_BRESP[1:0] = 2'd0;
    step();
    check("merge_bready_t1", bus.m_axi_BREADY, 3'b110);
    step();
    bus.m_axi_BVALID[1] = 1'b1; bus.m_axi_BRESP[3:2] = 2'd2;
    step();
    check("merge_bready_t3", bus.m_axi_BREADY, 3'b100);
    step();
    check("merge_bvalid_t4", bus.s_axi_control_BVALID, 1'b0);
    bus.m_axi_BVALID[2] = 1'b1; bus.m_axi_BRESP[5:4] = 2'd0;
    step();
    bus.m_axi_BVALID[0] = 1'b1; bus.m_axi_BRESP[1:0] = 2'd3;
    repeat (4) begin
      check("merge_bvalid_held", bus.s_axi_control_BVALID, 1'b1);
      check("merge_bresp_held", bus.s_axi_control_BRESP, 2'd2);
      check("merge_m_bready_off", bus.m_axi_BREADY, 3'b000);
      step();
    end
    check("merge_m_bready0_off", bus.m_axi_BREADY[0], 1'b0);
    bus.s_axi_control_BREADY = 1'b1;
    step();
    bus.s_axi_control_BREADY = 1'b0;
    check("merge_bvalid_gone", bus.s_axi_control_BVALID, 1'b0);
    check("merge_m_bready_back", bus.m_axi_BREADY, 3'b111);
    step();
    check("merge_b0_taken", bus.m_axi_BREADY, 3'b110);

    // Reset while AW is held with only branch 1 served
    bus.m_axi_AWREADY = 3'b010;
    bus.s_axi_control_AWVALID = 1'b1; bus.s_axi_control_AWADDR = 9'h0AA;
    step();
    check("mrst_m_awvalid_t1", bus.m_axi_AWVALID, 3'b111);
    step();
    check("mrst_m_awvalid_t2", bus.m_axi_AWVALID, 3'b101);
    ap_rst = 1'b1;
    step();
    check("mrst_m_awvalid", bus.m_axi_AWVALID, 3'b000);
    check("mrst_awready", bus.s_axi_control_AWREADY, 1'b0);
    check("mrst_m_bready", bus.m_axi_BREADY, 3'b000);
    ap_rst = 1'b0;
    bus.m_axi_AWREADY = 3'b111;
    step();
    repeat (5) begin
      check("mrst_no_stale_aw", bus.m_axi_AWVALID, 3'b000);
      step();
    end

    // Randomized traffic against the model
    for (int c = 0; c < 800; c++) begin
      if (!bus.s_axi_control_AWVALID && ($urandom_range(0, 2) == 0)) begin
        bus.s_axi_control_AWVALID = 1'b1;
        bus.s_axi_control_AWADDR  = AW'($urandom);
      end
      if (!bus.s_axi_control_WVALID && ($urandom_range(0, 2) == 0)) begin
        bus.s_axi_control_WVALID = 1'b1;
        bus.s_axi_control_WDATA  = $urandom;
        bus.s_axi_control_WSTRB  = SW'($urandom);
      end
      for (int i = 0; i < NB; i++) begin
        bus.m_axi_AWREADY[i] = ($urandom_range(0, 3) != 0);
        bus.m_axi_WREADY[i]  = ($urandom_range(0, 3) != 0);
        if (!bus.m_axi_BVALID[i] && ($urandom_range(0, 3) == 0)) begin
          bus.m_axi_BVALID[i]       = 1'b1;
          bus.m_axi_BRESP[i*2 +: 2] = 2'($urandom_range(0, 3));
        end
      end
      bus.s_axi_control_BREADY = ($urandom_range(0, 1) == 1);
      step();
    end

    // Drain: everything accepted upstream must have reached every branch
    bus.m_axi_AWREADY = '1;
    bus.m_axi_WREADY  = '1;
    repeat (12) step();
    check("drain_aw_accepted", bus.s_axi_control_AWVALID, 1'b0);
    check("drain_w_accepted", bus.s_axi_control_WVALID, 1'b0);
    check("drain_m_valid_idle", {bus.m_axi_AWVALID, bus.m_axi_WVALID}, 6'b0);
    for (int i = 0; i < NB; i++) begin
      check("drain_aw_delivered", aw_q[i].size(), 0);
      check("drain_w_delivered", w_q[i].size(), 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
